lvds_scan_ctrl: RTL and testbench
=================================

# lvds_scan_ctrl

Raster scan controller for the LVDS panel path. Generates panel timing (HSync, VSync, DataEnable) and schedules reads from the image RAM, upscaling a stored IMG_W×IMG_H image by an integer SCALE into a window at the panel origin. Merges RAM pixels with a marker column and a background colour, and delivers latency-aligned RGB plus syncs to the LVDS encoder. Runs entirely in the pixel-clock domain, i.e. the DCM CLKFX output.

## Interface
Parameters:
- H_ACTIVE, 1366, visible columns
- H_BLANK, 50, horizontal blanking cycles; H_TOTAL = H_ACTIVE+H_BLANK
- V_ACTIVE, 767, visible lines
- V_BLANK, 12, vertical blanking lines; V_TOTAL = V_ACTIVE+V_BLANK
- HS_FP / HS_W, 8 / 16, HSync offset after active region / width in cycles
- VS_FP / VS_W, 2 / 4, VSync offset after active region / width in lines
- IMG_W / IMG_H, 100 / 100, stored image size in pixels
- SCALE, 4, integer upscale factor (≥1); window is IMG_W·SCALE × IMG_H·SCALE
- ADDR_W, 14, RAM address width (≥ clog2(IMG_W·IMG_H))
- MARK_X, 450, column forced to white
- BG_RGB, 24'h000000, colour for active pixels outside the window

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- rd_en  out  1  RAM read enable
- rd_addr  out  ADDR_W  RAM read address
- rd_r / rd_g / rd_b  in  8 each  RAM data, valid one clock after rd_en/rd_addr
- hsync  out  1  active-low
- vsync  out  1  active-low
- de  out  1  data enable
- red / green / blue  out  8 each  pixel colour
- frame_start  out  1  one-cycle pulse, aligned with first active pixel of frame

## Operation
- Counters x ∈ [0, H_TOTAL−1] and y ∈ [0, V_TOTAL−1]. x increments every clock. At x = H_TOTAL−1, x wraps to 0 and y increments, wrapping to 0 at V_TOTAL−1.
- Raw timing, stage 0:
  - act = (x < H_ACTIVE) & (y < V_ACTIVE)
  - hs_n = 0 iff H_ACTIVE+HS_FP ≤ x < H_ACTIVE+HS_FP+HS_W
  - vs_n = 0 iff V_ACTIVE+VS_FP ≤ y < V_ACTIVE+VS_FP+VS_W
  - win = (x < IMG_W·SCALE) & (y < IMG_H·SCALE)
- Address scheduler uses no multipliers or dividers, only counters and adders:
  - sx (column sub-count), sy (line sub-count), row_base, addr
  - At x = 0 with y in window: addr ← row_base, sx ← 0.
  - On each window pixel: when sx = SCALE−1, sx ← 0 and addr ← addr+1; otherwise sx ← sx+1.
  - At x = H_TOTAL−1 with y in window: when sy = SCALE−1, sy ← 0 and row_base ← row_base+IMG_W; otherwise sy ← sy+1.
  - At x = H_TOTAL−1, y = V_TOTAL−1: row_base ← 0, sy ← 0.
- rd_en = registered win. rd_addr = registered addr, holding its last value when rd_en = 0.
- Pixel mux, priority order:
  1. !act → RGB 0
  2. x = MARK_X → FF/FF/FF
  3. win → rd_r/g/b
  4. otherwise → BG_RGB
- frame_start = act & x = 0 & y = 0, delayed with the video outputs.

## Timing
- Pipeline, with the counter at (x, y) in cycle t:
  - t+1: rd_en/rd_addr for that pixel
  - t+2: RAM data valid
  - t+3: red/green/blue, de, hsync, vsync, frame_start registered together
- Video outputs therefore lag the counters by exactly 3 clocks. Stage-0 flags are delayed through a matching shift register.
- Reset values:
  - x = y = 0; sx = sy = row_base = addr = 0
  - rd_en = 0, rd_addr = 0
  - hsync = vsync = 1, de = 0, RGB = 0, frame_start = 0
  - All delay-line stages cleared.
- Reset mid-frame: all state returns to reset values on the next edge. The first frame_start after deassertion occurs 3 clocks after the first cycle with x = y = 0. No partial frame is emitted with stale addresses.
- Address range: last window pixel reads (IMG_W·IMG_H−1). rd_addr never exceeds it. The next frame restarts at 0.
- Marker column and window overlap: the marker wins, but RAM is still read (rd_en is not gated by the marker).
- SCALE = 1: addr increments every window pixel and row_base every window line.

## Test plan
- Reset: assert rst for 5 clocks mid-line → all outputs at reset values while asserted; frame_start is seen at 3 clocks after x = y = 0.
- Frame timing (defaults): measure periods → hsync period 1416 clocks, low for 16 clocks starting 3+1374 after line start; vsync low for 4 lines; frame = 1,103,064 clocks; de high 1366 clocks per line on 767 lines.
- Address sequence, line 0: rd_addr = 0,0,0,0,1,1,1,1,…,99 (400 cycles of rd_en); lines 0–3 repeat 0..99; line 4 starts at 100; line 399 ends at 9999; line 400 has rd_en = 0.
- Data alignment: RAM model returns rd_addr[7:0] on red → red at output equals the address issued 2 clocks earlier, with de = 1 on that cycle.
- Marker and background: BG_RGB = 24'h102030 → column 450 is FFFFFF on all active lines; column 500 is 10/20/30; column 10 carries RAM data; blanking is 0.
- Small-geometry run: H_ACTIVE 8, H_BLANK 4, V_ACTIVE 6, V_BLANK 2, IMG 2×2, SCALE 2 → addresses 0,0,1,1 on lines 0–1 and 2,2,3,3 on lines 2–3; wrap to 0 on the next frame.

Source files
------------

// File: rtl/lvds_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lvds_scan_ctrl
// Description : Raster timing generator and image-RAM read scheduler with
//               integer upscaling, marker column and background fill.
// Revision    : 1.0 - initial release
// ============================================================================
module lvds_scan_ctrl #(
    parameter int          H_ACTIVE = 1366,
    parameter int          H_BLANK  = 50,
    parameter int          V_ACTIVE = 767,
    parameter int          V_BLANK  = 12,
    parameter int          HS_FP    = 8,
    parameter int          HS_W     = 16,
    parameter int          VS_FP    = 2,
    parameter int          VS_W     = 4,
    parameter int          IMG_W    = 100,
    parameter int          IMG_H    = 100,
    parameter int          SCALE    = 4,
    parameter int          ADDR_W   = 14,
    parameter int          MARK_X   = 450,
    parameter logic [23:0] BG_RGB   = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_r,
    input  logic [7:0]        rd_g,
    input  logic [7:0]        rd_b,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              frame_start
);
    localparam int c_H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int c_V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int c_X_W     = $clog2(c_H_TOTAL);
    localparam int c_Y_W     = $clog2(c_V_TOTAL);
    localparam int c_S_W     = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(c_H_TOTAL - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(c_V_TOTAL - 1);
    localparam logic [c_S_W-1:0] c_S_LAST = c_S_W'(SCALE - 1);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic win;
        logic mark;
        logic fs;
    } flags_t;

    logic [c_X_W-1:0]  r_x;
    logic [c_Y_W-1:0]  r_y;
    logic [31:0]       w_x32;
    logic [31:0]       w_y32;
    logic              w_x_last;
    logic              w_y_last;
    logic              w_win_y;
    flags_t            w_f0;
    flags_t            r_f1;
    flags_t            r_f2;
    logic [c_S_W-1:0]  r_sx;
    logic [c_S_W-1:0]  r_sy;
    logic [c_S_W-1:0]  w_sx_cur;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_cur;
    logic [23:0]       w_rgb;

    assign w_x32    = 32'(r_x);
    assign w_y32    = 32'(r_y);
    assign w_x_last = (r_x == c_X_LAST);
    assign w_y_last = (r_y == c_Y_LAST);
    assign w_win_y  = (w_y32 < 32'(IMG_H * SCALE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_x_last) begin
            r_x <= '0;
            r_y <= w_y_last ? '0 : r_y + c_Y_W'(1);
        end else begin
            r_x <= r_x + c_X_W'(1);
        end
    end

    always_comb begin
        w_f0      = '0;
        w_f0.act  = (w_x32 < 32'(H_ACTIVE)) && (w_y32 < 32'(V_ACTIVE));
        w_f0.hs   = (w_x32 >= 32'(H_ACTIVE + HS_FP)) && (w_x32 < 32'(H_ACTIVE + HS_FP + HS_W));
        w_f0.vs   = (w_y32 >= 32'(V_ACTIVE + VS_FP)) && (w_y32 < 32'(V_ACTIVE + VS_FP + VS_W));
        w_f0.win  = (w_x32 < 32'(IMG_W * SCALE)) && w_win_y;
        w_f0.mark = (w_x32 == 32'(MARK_X));
        w_f0.fs   = w_f0.act && (r_x == '0) && (r_y == '0);
    end

    // Start of line reloads the column state from the row base in the same cycle.
    assign w_sx_cur   = (r_x == '0) ? '0 : r_sx;
    assign w_addr_cur = (r_x == '0) ? r_row_base : r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sx       <= '0;
            r_sy       <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else begin
            if (w_f0.win) begin
                if (w_sx_cur == c_S_LAST) begin
                    r_sx   <= '0;
                    r_addr <= w_addr_cur + ADDR_W'(1);
                end else begin
                    r_sx   <= w_sx_cur + c_S_W'(1);
                    r_addr <= w_addr_cur;
                end
            end
            if (w_x_last) begin
                if (w_y_last) begin
                    r_sy       <= '0;
                    r_row_base <= '0;
                end else if (w_win_y) begin
                    if (r_sy == c_S_LAST) begin
                        r_sy       <= '0;
                        r_row_base <= r_row_base + ADDR_W'(IMG_W);
                    end else begin
                        r_sy <= r_sy + c_S_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            r_f1    <= '0;
            r_f2    <= '0;
        end else begin
            rd_en <= w_f0.win;
            if (w_f0.win) begin
                rd_addr <= w_addr_cur;
            end
            r_f1 <= w_f0;
            r_f2 <= r_f1;
        end
    end

    // Marker overrides RAM data, but the read itself still happens.
    always_comb begin
        w_rgb = 24'h000000;
        if (!r_f2.act) begin
            w_rgb = 24'h000000;
        end else if (r_f2.mark) begin
            w_rgb = 24'hFFFFFF;
        end else if (r_f2.win) begin
            w_rgb = {rd_r, rd_g, rd_b};
        end else begin
            w_rgb = BG_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync              <= 1'b1;
            vsync              <= 1'b1;
            de                 <= 1'b0;
            {red, green, blue} <= 24'h000000;
            frame_start        <= 1'b0;
        end else begin
            hsync              <= ~r_f2.hs;
            vsync              <= ~r_f2.vs;
            de                 <= r_f2.act;
            {red, green, blue} <= w_rgb;
            frame_start        <= r_f2.fs;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lvds_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lvds_scan_ctrl
// Description : Self-checking bench for lvds_scan_ctrl on a small geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lvds_scan_ctrl;
    localparam int HA = 8, HB = 4, VA = 6, VB = 2;
    localparam int HFP = 1, HW = 2, VFP = 0, VW = 1;
    localparam int IW = 2, IH = 2, S = 2, AW = 4, MX = 2;
    localparam logic [23:0] BG = 24'h102030;
    localparam int HT = HA + HB, VT = VA + VB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_r = 8'h00, rd_g = 8'h00, rd_b = 8'h00;
    logic          hsync, vsync, de, frame_start;
    logic [7:0]    red, green, blue;

    int   total = 0;
    int   bad = 0;
    int   n = 0;
    bit   armed = 1'b0;
    int   seg = 0;
    int   de_cnt = 0;
    logic [31:0] hold = 0;
    logic        exp_en;
    logic [31:0] addr_q[$];
    logic [31:0] exp_seq[16] = '{0,0,1,1, 0,0,1,1, 2,2,3,3, 2,2,3,3};

    lvds_scan_ctrl #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .HS_FP(HFP), .HS_W(HW), .VS_FP(VFP), .VS_W(VW),
        .IMG_W(IW), .IMG_H(IH), .SCALE(S), .ADDR_W(AW),
        .MARK_X(MX), .BG_RGB(BG)
    ) u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_r(rd_r), .rd_g(rd_g), .rd_b(rd_b),
        .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Image RAM: colour channels are distinct functions of the address.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_r <= 8'(rd_addr);
            rd_g <= ~8'(rd_addr);
            rd_b <= 8'(rd_addr) + 8'h40;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            n     <= 0;
            armed <= 1'b1;
        end else begin
            n <= n + 1;
        end
    end

    function automatic int px_x(int p); return p % HT; endfunction
    function automatic int px_y(int p); return (p / HT) % VT; endfunction
    function automatic bit px_act(int p); return px_x(p) < HA && px_y(p) < VA; endfunction
    function automatic bit px_win(int p); return px_x(p) < IW * S && px_y(p) < IH * S; endfunction
    function automatic logic [31:0] px_addr(int p);
        return 32'((px_y(p) / S) * IW + px_x(p) / S);
    endfunction
    function automatic logic [3:0] px_sync(int p);
        bit hs, vs, fs;
        hs = px_x(p) >= HA + HFP && px_x(p) < HA + HFP + HW;
        vs = px_y(p) >= VA + VFP && px_y(p) < VA + VFP + VW;
        fs = px_act(p) && px_x(p) == 0 && px_y(p) == 0;
        return {px_act(p), ~hs, ~vs, fs};
    endfunction
    function automatic logic [23:0] px_rgb(int p);
        logic [7:0] a;
        a = 8'(px_addr(p));
        if (!px_act(p)) return 24'h000000;
        if (px_x(p) == MX) return 24'hFFFFFF;
        if (px_win(p)) return {a, ~a, a + 8'h40};
        return BG;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s n=%0d got=%h exp=%h", name, n, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            if (n >= 1) begin
                exp_en = px_win(n - 1);
                if (exp_en) hold = px_addr(n - 1);
            end else begin
                exp_en = 1'b0;
                hold   = 0;
            end
            chk("rd_en", 32'(rd_en), 32'(exp_en));
            chk("rd_addr", 32'(rd_addr), hold);
            if (n >= 3) begin
                chk("rgb", {8'h00, red, green, blue}, 32'(px_rgb(n - 3)));
                chk("sync", 32'({de, hsync, vsync, frame_start}), 32'(px_sync(n - 3)));
            end else begin
                chk("rgb_reset", {8'h00, red, green, blue}, 32'h0);
                chk("sync_reset", 32'({de, hsync, vsync, frame_start}), 32'b0110);
            end
            // Hand-computed pins of the model
            if (n == 3)  chk("pin_first_px", {de, hsync, vsync, frame_start, 4'h0, red, green, blue}, 32'hF000FF40);
            if (n == 5)  chk("pin_marker_in_win", {8'h00, red, green, blue}, 32'h00FFFFFF);
            if (n == 7)  chk("pin_background", {8'h00, red, green, blue}, 32'h00102030);
            if (n == 12) chk("pin_hblank", {de, hsync, vsync, frame_start, 4'h0, red, green, blue}, 32'h20000000);
            if (n == 30) chk("pin_px_3_2", {8'h00, red, green, blue}, 32'h0003FC43);
            if (n == 75) chk("pin_vsync", 32'({de, hsync, vsync, frame_start}), 32'b0100);
            if (n == 97) chk("pin_frame_wrap", 32'({rd_en, rd_addr}), 32'h10);
            if (n == 99) chk("pin_frame_period", 32'(frame_start), 32'h1);
            if (seg == 0 && n >= 1 && n <= 96 && rd_en) addr_q.push_back(32'(rd_addr));
            if (seg == 0 && n >= 3 && n <= 98 && de) de_cnt++;
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (245) @(posedge clk);
        #1 rst = 1'b1;
        seg = 1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (210) @(posedge clk);
        #1;
        chk("addr_seq_len", 32'(addr_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < addr_q.size()) chk("addr_seq", addr_q[i], exp_seq[i]);
            else chk("addr_seq_missing", 32'hFFFFFFFF, exp_seq[i]);
        end
        chk("de_count", 32'(de_cnt), 32'd48);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
